// File: rtl/scv_pkg.sv
// scv_pkg: shared types and constants for the scv console core.
//   mapper_t       - cartridge mapper selection; MAPPER_AUTO picks a mapper from
//                    the cart size class reported by the ROMINIT receiver.
//   cart_class_t   - size class of the last loaded cartridge image.
//   CLASS_K*_MAX   - upper byte-count bounds of each size class.
//   tgt_t          - ROMINIT target memory.
//   rx_state_t     - ROMINIT receiver FSM states.
//   cart_class_f   - maps a byte count onto cart_class_t.
package scv_pkg;

   typedef enum logic [1:0] {
      MAPPER_AUTO   = 2'd0,
      MAPPER_LINEAR = 2'd1,
      MAPPER_BANKED = 2'd2
   } mapper_t;

   typedef enum logic [2:0] {
      CLASS_NONE = 3'd0,
      CLASS_K8   = 3'd1,
      CLASS_K16  = 3'd2,
      CLASS_K32  = 3'd3,
      CLASS_K64  = 3'd4,
      CLASS_K128 = 3'd5
   } cart_class_t;

   localparam logic [31:0] CLASS_K8_MAX  = 32'd8192;
   localparam logic [31:0] CLASS_K16_MAX = 32'd16384;
   localparam logic [31:0] CLASS_K32_MAX = 32'd32768;
   localparam logic [31:0] CLASS_K64_MAX = 32'd65536;

   typedef enum logic [1:0] {
      TGT_BOOT = 2'd0,
      TGT_CHR  = 2'd1,
      TGT_APU  = 2'd2,
      TGT_CART = 2'd3
   } tgt_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_FINISH = 2'd2
   } rx_state_t;

   function automatic cart_class_t cart_class_f(input logic [31:0] size);
      if (size == 32'd0)               return CLASS_NONE;
      else if (size <= CLASS_K8_MAX)   return CLASS_K8;
      else if (size <= CLASS_K16_MAX)  return CLASS_K16;
      else if (size <= CLASS_K32_MAX)  return CLASS_K32;
      else if (size <= CLASS_K64_MAX)  return CLASS_K64;
      else                             return CLASS_K128;
   endfunction

endpackage

// File: rtl/rominit_range_chk.sv
// rominit_range_chk: address range check and highest-accepted-address tracker
// for the ROMINIT receiver.
//   clk, rst_n  - clock, asynchronous active-low reset
//   aw          - address width of the currently selected target
//   addr        - incoming byte address
//   clear       - start of a new session: forget the tracked maximum
//   accept      - the byte at addr is being written this cycle
//   in_range    - addr < 2**aw (combinational)
//   max_addr    - highest accepted address of the session
//   any_acc     - at least one byte accepted in this session
// MAX_W must be the widest target width (the cartridge), so every accepted
// address fits in the tracker.
module rominit_range_chk #(
   parameter int ADDR_W   = 25,
   parameter int AW_SEL_W = 5,
   parameter int MAX_W    = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [AW_SEL_W-1:0] aw,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                clear,
   input  logic                accept,
   output logic                in_range,
   output logic [MAX_W-1:0]    max_addr,
   output logic                any_acc
);

   logic [MAX_W-1:0] max_addr_q, max_addr_d;
   logic             any_q, any_d;

   // In range when no bit at or above the target width is set.
   assign in_range = ((addr >> aw) == '0);

   always_comb begin
      max_addr_d = max_addr_q;
      any_d      = any_q;
      if (clear) begin
         max_addr_d = '0;
         any_d      = 1'b0;
      end else if (accept) begin
         any_d = 1'b1;
         if (addr[MAX_W-1:0] > max_addr_q) max_addr_d = addr[MAX_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_addr_q <= '0;
         any_q      <= 1'b0;
      end else begin
         max_addr_q <= max_addr_d;
         any_q      <= any_d;
      end
   end

   assign max_addr = max_addr_q;
   assign any_acc  = any_q;

endmodule

// File: rtl/rominit_rx.sv
// rominit_rx: receiving end of the ROMINIT byte stream.
//   CLK, RESB             - clock, asynchronous active-low reset
//   ROMINIT_SEL_*         - target select levels, held for a whole session
//   ROMINIT_ADDR/DATA     - byte address within the target and byte value
//   ROMINIT_VALID         - byte qualifier; one byte per cycle, no backpressure
//                           (there is no ready: a byte with VALID in LOAD is
//                           either written or flagged as an error that cycle)
//   WDATA, *_WE, *_A      - registered write port per target, 1 cycle latency
//   CART_SIZE, CART_CLASS - byte count and size class of the last cart session
//   LOAD_DONE             - one-cycle pulse at the end of a session
//   LOAD_ERR              - sticky error, cleared when the next session starts
//   DBG_STATE             - current FSM state (rx_state_t encoding)
module rominit_rx
   import scv_pkg::*;
#(
   parameter int CART_AW = 17,
   parameter int BOOT_AW = 12,
   parameter int CHR_AW  = 10,
   parameter int APU_AW  = 10
) (
   input  logic               CLK,
   input  logic               RESB,
   input  logic               ROMINIT_SEL_BOOT,
   input  logic               ROMINIT_SEL_CHR,
   input  logic               ROMINIT_SEL_APU,
   input  logic               ROMINIT_SEL_CART,
   input  logic [24:0]        ROMINIT_ADDR,
   input  logic [7:0]         ROMINIT_DATA,
   input  logic               ROMINIT_VALID,
   output logic [7:0]         WDATA,
   output logic               BOOT_WE,
   output logic               CHR_WE,
   output logic               APU_WE,
   output logic               CART_WE,
   output logic [BOOT_AW-1:0] BOOT_A,
   output logic [CHR_AW-1:0]  CHR_A,
   output logic [APU_AW-1:0]  APU_A,
   output logic [CART_AW-1:0] CART_A,
   output logic [CART_AW:0]   CART_SIZE,
   output cart_class_t        CART_CLASS,
   output logic               LOAD_DONE,
   output logic               LOAD_ERR,
   output logic [1:0]         DBG_STATE
);

   logic [3:0]         sel;
   logic [2:0]         sel_cnt;
   tgt_t               sel_tgt;
   logic [3:0]         tgt_mask;
   logic               own_sel;
   logic               other_sel;
   logic [4:0]         aw_sel;
   logic               in_range;
   logic [CART_AW-1:0] max_addr;
   logic               any_acc;
   logic               accept;
   logic               clear_max;
   logic [CART_AW:0]   cart_size_new;

   rx_state_t          state_q, state_d;
   tgt_t               tgt_q, tgt_d;
   logic               err_q, err_d;
   logic               blocked_q, blocked_d;
   logic               done_q, done_d;
   logic [3:0]         we_q, we_d;
   logic [7:0]         wdata_q, wdata_d;
   logic [BOOT_AW-1:0] boot_a_q, boot_a_d;
   logic [CHR_AW-1:0]  chr_a_q, chr_a_d;
   logic [APU_AW-1:0]  apu_a_q, apu_a_d;
   logic [CART_AW-1:0] cart_a_q, cart_a_d;
   logic [CART_AW:0]   cart_size_q, cart_size_d;
   cart_class_t        cart_class_q, cart_class_d;

   // Bit order matches tgt_t so a target indexes its own select bit.
   assign sel     = {ROMINIT_SEL_CART, ROMINIT_SEL_APU, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
   assign sel_cnt = 3'($countones(sel));

   always_comb begin
      case (sel)
         4'b0010: sel_tgt = TGT_CHR;
         4'b0100: sel_tgt = TGT_APU;
         4'b1000: sel_tgt = TGT_CART;
         default: sel_tgt = TGT_BOOT;
      endcase
   end

   always_comb begin
      case (tgt_q)
         TGT_BOOT: aw_sel = 5'(BOOT_AW);
         TGT_CHR:  aw_sel = 5'(CHR_AW);
         TGT_APU:  aw_sel = 5'(APU_AW);
         default:  aw_sel = 5'(CART_AW);
      endcase
   end

   assign tgt_mask  = 4'b0001 << tgt_q;
   assign own_sel   = |(sel & tgt_mask);
   assign other_sel = |(sel & ~tgt_mask);

   // A foreign select during LOAD makes the byte bus ambiguous, so nothing is
   // written while it is high.
   assign accept    = (state_q == ST_LOAD) && ROMINIT_VALID && in_range && !other_sel;
   assign clear_max = (state_q == ST_IDLE) && !blocked_q && (sel_cnt == 3'd1);

   assign cart_size_new = any_acc ? ((CART_AW+1)'(max_addr) + (CART_AW+1)'(1)) : '0;

   rominit_range_chk #(
      .ADDR_W   (25),
      .AW_SEL_W (5),
      .MAX_W    (CART_AW)
   ) u_range_chk (
      .clk      (CLK),
      .rst_n    (RESB),
      .aw       (aw_sel),
      .addr     (ROMINIT_ADDR),
      .clear    (clear_max),
      .accept   (accept),
      .in_range (in_range),
      .max_addr (max_addr),
      .any_acc  (any_acc)
   );

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      err_d        = err_q;
      blocked_d    = blocked_q;
      done_d       = 1'b0;
      we_d         = 4'b0000;
      wdata_d      = wdata_q;
      boot_a_d     = boot_a_q;
      chr_a_d      = chr_a_q;
      apu_a_d      = apu_a_q;
      cart_a_d     = cart_a_q;
      cart_size_d  = cart_size_q;
      cart_class_d = cart_class_q;

      case (state_q)
         ST_IDLE: begin
            // After a select conflict, all selects must go low before a new
            // session can start; otherwise the survivor of a conflict would
            // start a session with a half-presented stream.
            if (sel_cnt == 3'd0) blocked_d = 1'b0;
            if (clear_max) begin
               state_d = ST_LOAD;
               tgt_d   = sel_tgt;
               err_d   = 1'b0;
            end else if (sel_cnt > 3'd1) begin
               err_d     = 1'b1;
               blocked_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               we_d    = tgt_mask;
               wdata_d = ROMINIT_DATA;
               case (tgt_q)
                  TGT_BOOT: boot_a_d = ROMINIT_ADDR[BOOT_AW-1:0];
                  TGT_CHR:  chr_a_d  = ROMINIT_ADDR[CHR_AW-1:0];
                  TGT_APU:  apu_a_d  = ROMINIT_ADDR[APU_AW-1:0];
                  default:  cart_a_d = ROMINIT_ADDR[CART_AW-1:0];
               endcase
            end
            if (other_sel || (ROMINIT_VALID && !in_range)) err_d = 1'b1;
            // The byte in the cycle the select drops is still written above.
            if (!own_sel) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (tgt_q == TGT_CART) begin
               cart_size_d  = cart_size_new;
               cart_class_d = cart_class_f(32'(cart_size_new));
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state_q      <= ST_IDLE;
         tgt_q        <= TGT_BOOT;
         err_q        <= 1'b0;
         blocked_q    <= 1'b0;
         done_q       <= 1'b0;
         we_q         <= 4'b0000;
         wdata_q      <= '0;
         boot_a_q     <= '0;
         chr_a_q      <= '0;
         apu_a_q      <= '0;
         cart_a_q     <= '0;
         cart_size_q  <= '0;
         cart_class_q <= CLASS_NONE;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         err_q        <= err_d;
         blocked_q    <= blocked_d;
         done_q       <= done_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         boot_a_q     <= boot_a_d;
         chr_a_q      <= chr_a_d;
         apu_a_q      <= apu_a_d;
         cart_a_q     <= cart_a_d;
         cart_size_q  <= cart_size_d;
         cart_class_q <= cart_class_d;
      end
   end

   assign WDATA      = wdata_q;
   assign BOOT_WE    = we_q[0];
   assign CHR_WE     = we_q[1];
   assign APU_WE     = we_q[2];
   assign CART_WE    = we_q[3];
   assign BOOT_A     = boot_a_q;
   assign CHR_A      = chr_a_q;
   assign APU_A      = apu_a_q;
   assign CART_A     = cart_a_q;
   assign CART_SIZE  = cart_size_q;
   assign CART_CLASS = cart_class_q;
   assign LOAD_DONE  = done_q;
   assign LOAD_ERR   = err_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_rominit_rx.sv
// tb_rominit_rx: self-checking bench for rominit_rx. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_rominit_rx;
   import scv_pkg::*;

   localparam int CART_AW = 17;
   localparam int BOOT_AW = 12;
   localparam int CHR_AW  = 10;
   localparam int APU_AW  = 10;
   localparam int T_BOOT  = 0;
   localparam int T_CHR   = 1;
   localparam int T_APU   = 2;
   localparam int T_CART  = 3;

   logic               clk;
   logic               resb;
   logic               sel_boot, sel_chr, sel_apu, sel_cart;
   logic [24:0]        addr;
   logic [7:0]         data;
   logic               valid;
   logic [7:0]         wdata;
   logic               boot_we, chr_we, apu_we, cart_we;
   logic [BOOT_AW-1:0] boot_a;
   logic [CHR_AW-1:0]  chr_a;
   logic [APU_AW-1:0]  apu_a;
   logic [CART_AW-1:0] cart_a;
   logic [CART_AW:0]   cart_size;
   cart_class_t        cart_class;
   logic               load_done;
   logic               load_err;
   logic [1:0]         dbg_state;

   rominit_rx #(
      .CART_AW (CART_AW),
      .BOOT_AW (BOOT_AW),
      .CHR_AW  (CHR_AW),
      .APU_AW  (APU_AW)
   ) dut (
      .CLK              (clk),
      .RESB             (resb),
      .ROMINIT_SEL_BOOT (sel_boot),
      .ROMINIT_SEL_CHR  (sel_chr),
      .ROMINIT_SEL_APU  (sel_apu),
      .ROMINIT_SEL_CART (sel_cart),
      .ROMINIT_ADDR     (addr),
      .ROMINIT_DATA     (data),
      .ROMINIT_VALID    (valid),
      .WDATA            (wdata),
      .BOOT_WE          (boot_we),
      .CHR_WE           (chr_we),
      .APU_WE           (apu_we),
      .CART_WE          (cart_we),
      .BOOT_A           (boot_a),
      .CHR_A            (chr_a),
      .APU_A            (apu_a),
      .CART_A           (cart_a),
      .CART_SIZE        (cart_size),
      .CART_CLASS       (cart_class),
      .LOAD_DONE        (load_done),
      .LOAD_ERR         (load_err),
      .DBG_STATE        (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no summary, required completion");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard and reference model ----------------
   int          errors;
   int          checks;
   logic [34:0] exp_q[$];   // {target, address, data} of each expected write
   logic        exp_done;
   int          we_cnt[4];
   int          m_size;
   cart_class_t m_class;
   int          s_tgt;
   int          s_aw;
   int          s_max;
   logic        s_any;
   logic        s_err;

   function automatic int aw_of(input int t);
      case (t)
         T_BOOT:  return BOOT_AW;
         T_CHR:   return CHR_AW;
         T_APU:   return APU_AW;
         default: return CART_AW;
      endcase
   endfunction

   function automatic cart_class_t ref_class(input int size);
      if (size == 0)                          return CLASS_NONE;
      else if (size <= int'(CLASS_K8_MAX))    return CLASS_K8;
      else if (size <= int'(CLASS_K16_MAX))   return CLASS_K16;
      else if (size <= int'(CLASS_K32_MAX))   return CLASS_K32;
      else if (size <= int'(CLASS_K64_MAX))   return CLASS_K64;
      else                                    return CLASS_K128;
   endfunction

   function automatic logic [34:0] observed();
      if (boot_we)      return {2'(T_BOOT), 25'(boot_a), wdata};
      else if (chr_we)  return {2'(T_CHR),  25'(chr_a),  wdata};
      else if (apu_we)  return {2'(T_APU),  25'(apu_a),  wdata};
      else if (cart_we) return {2'(T_CART), 25'(cart_a), wdata};
      else              return '0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_sel(input logic [3:0] s);
      {sel_cart, sel_apu, sel_chr, sel_boot} = s;
   endtask

   // One clock: every predicted write must appear exactly one cycle after
   // its byte, nothing else may be written, and LOAD_DONE must match.
   task automatic tick();
      logic [34:0] e;
      logic [34:0] o;
      int          nwe;
      @(posedge clk);
      @(negedge clk);
      nwe = int'(boot_we) + int'(chr_we) + int'(apu_we) + int'(cart_we);
      if (boot_we) we_cnt[0]++;
      if (chr_we)  we_cnt[1]++;
      if (apu_we)  we_cnt[2]++;
      if (cart_we) we_cnt[3]++;
      o = observed();
      checks++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (nwe != 1 || o !== e) begin
            errors++;
            $display("FAIL write: got we_count=%0d tgt/addr/data=%h, required one write %h", nwe, o, e);
         end
      end else if (nwe != 0) begin
         errors++;
         $display("FAIL spurious_write: got we_count=%0d tgt/addr/data=%h, required no write", nwe, o);
      end
      checks++;
      if (load_done !== exp_done) begin
         errors++;
         $display("FAIL load_done: got %b, required %b", load_done, exp_done);
      end
   endtask

   task automatic init_session(input int t);
      s_tgt = t;
      s_aw  = aw_of(t);
      s_max = 0;
      s_any = 1'b0;
      s_err = 1'b0;
   endtask

   // Byte presented during LOAD; the model decides whether it is written.
   task automatic send(input int a, input logic [7:0] d);
      addr  = 25'(a);
      data  = d;
      valid = 1'b1;
      if (a < (1 << s_aw)) begin
         exp_q.push_back({2'(s_tgt), 25'(a), d});
         s_any = 1'b1;
         if (a > s_max) s_max = a;
      end else begin
         s_err = 1'b1;
      end
      tick();
      valid = 1'b0;
      addr  = 25'($urandom);
      data  = 8'($urandom);
   endtask

   // Byte presented when the receiver must not write anything.
   task automatic send_ignored(input int a, input logic [7:0] d);
      addr  = 25'(a);
      data  = d;
      valid = 1'b1;
      tick();
      valid = 1'b0;
   endtask

   task automatic start_session(input int t);
      set_sel(4'(1 << t));
      valid = 1'b0;
      tick();
      init_session(t);
      checks++;
      if (load_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear_on_start: got LOAD_ERR=%b, required 0", load_err);
      end
   endtask

   task automatic end_session(input logic last, input int a, input logic [7:0] d);
      set_sel(4'b0000);
      if (last) send(a, d);
      else tick();
      exp_done = 1'b1;
      tick();
      exp_done = 1'b0;
      if (s_tgt == T_CART) begin
         m_size  = s_any ? s_max + 1 : 0;
         m_class = ref_class(m_size);
      end
      checks++;
      if (cart_size !== (CART_AW+1)'(m_size)) begin
         errors++;
         $display("FAIL cart_size: got %0d, required %0d", cart_size, m_size);
      end
      checks++;
      if (cart_class !== m_class) begin
         errors++;
         $display("FAIL cart_class: got %0d, required %0d", cart_class, m_class);
      end
      checks++;
      if (load_err !== s_err) begin
         errors++;
         $display("FAIL load_err_end: got %b, required %b", load_err, s_err);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) we_cnt[i] = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resb = 1'b0;
      set_sel(4'b0000);
      valid = 1'b0;
      addr  = '0;
      data  = '0;
      #2;
      checks++;
      if ({boot_we, chr_we, apu_we, cart_we, load_done, load_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b, required 000000",
                  {boot_we, chr_we, apu_we, cart_we, load_done, load_err});
      end
      checks++;
      if ({boot_a, chr_a, apu_a, cart_a, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_addr_data: got %h, required 0", {boot_a, chr_a, apu_a, cart_a, wdata});
      end
      checks++;
      if (cart_size !== '0 || cart_class !== CLASS_NONE) begin
         errors++;
         $display("FAIL reset_size_class: got %0d/%0d, required 0/0", cart_size, cart_class);
      end
      @(negedge clk);
      resb = 1'b1;
      tick();
   endtask

   task automatic test_boot();
      clear_counts();
      start_session(T_BOOT);
      for (int i = 0; i < 4096; i++) send(i, 8'(i));
      end_session(1'b0, 0, 8'h00);
      checks++;
      if (we_cnt[0] != 4096 || we_cnt[1] + we_cnt[2] + we_cnt[3] != 0) begin
         errors++;
         $display("FAIL boot_pulses: got boot=%0d other=%0d, required 4096/0",
                  we_cnt[0], we_cnt[1] + we_cnt[2] + we_cnt[3]);
      end
   endtask

   task automatic test_cart_24k();
      start_session(T_CART);
      for (int i = 0; i < 24576; i++) begin
         if ($urandom_range(0, 3) == 0) tick();
         send(i, 8'($urandom));
      end
      end_session(1'b0, 0, 8'h00);
      checks++;
      if (cart_size !== 18'd24576 || cart_class !== CLASS_K32) begin
         errors++;
         $display("FAIL cart_24k: got %0d/%0d, required 24576/K32", cart_size, cart_class);
      end
   endtask

   task automatic test_cart_8k_random_order();
      int a;
      start_session(T_CART);
      for (int i = 0; i < 8192; i++) begin
         a = (i == 4000) ? 8191 : int'($urandom_range(0, 8191));
         if ($urandom_range(0, 7) == 0) tick();
         send(a, 8'($urandom));
      end
      end_session(1'b0, 0, 8'h00);
      checks++;
      if (cart_size !== 18'd8192 || cart_class !== CLASS_K8) begin
         errors++;
         $display("FAIL cart_8k: got %0d/%0d, required 8192/K8", cart_size, cart_class);
      end
   endtask

   task automatic test_overflow();
      clear_counts();
      start_session(T_CHR);
      for (int i = 0; i <= 1024; i++) send(i, 8'($urandom));
      end_session(1'b0, 0, 8'h00);
      checks++;
      if (we_cnt[1] != 1024 || load_err !== 1'b1) begin
         errors++;
         $display("FAIL chr_overflow: got pulses=%0d err=%b, required 1024/1", we_cnt[1], load_err);
      end
      start_session(T_APU);
      for (int i = 0; i < 50; i++) send(int'($urandom_range(0, 1023)), 8'($urandom));
      end_session(1'b0, 0, 8'h00);
   endtask

   task automatic test_conflict();
      set_sel(4'b0000);
      for (int i = 0; i < 4; i++) send_ignored(int'($urandom_range(0, 255)), 8'($urandom));
      set_sel(4'b1100);
      for (int i = 0; i < 4; i++) send_ignored(int'($urandom_range(0, 255)), 8'($urandom));
      checks++;
      if (load_err !== 1'b1) begin
         errors++;
         $display("FAIL conflict_err: got %b, required 1", load_err);
      end
      // The survivor of a conflict must not start a session on its own.
      set_sel(4'b1000);
      for (int i = 0; i < 4; i++) send_ignored(int'($urandom_range(0, 255)), 8'($urandom));
      set_sel(4'b0000);
      tick();
      checks++;
      if (load_err !== 1'b1) begin
         errors++;
         $display("FAIL conflict_sticky: got %b, required 1", load_err);
      end
      start_session(T_CART);
      for (int i = 0; i < 20; i++) send(int'($urandom_range(0, (1 << CART_AW) - 1)), 8'($urandom));
      end_session(1'b0, 0, 8'h00);
   endtask

   task automatic test_last_byte();
      start_session(T_CART);
      for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 16'h7FFE)), 8'($urandom));
      end_session(1'b1, 32'h7FFF, 8'($urandom));
      checks++;
      if (cart_size !== 18'd32768 || cart_class !== CLASS_K32) begin
         errors++;
         $display("FAIL last_byte: got %0d/%0d, required 32768/K32", cart_size, cart_class);
      end
   endtask

   task automatic test_reset_mid();
      start_session(T_CART);
      for (int i = 0; i < 1000; i++) send(i, 8'($urandom));
      resb = 1'b0;
      #1;
      checks++;
      if ({boot_we, chr_we, apu_we, cart_we, load_done, load_err} !== 6'b0 ||
          {boot_a, chr_a, apu_a, cart_a, wdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got we/done/err=%b a/d=%h, required all 0",
                  {boot_we, chr_we, apu_we, cart_we, load_done, load_err},
                  {boot_a, chr_a, apu_a, cart_a, wdata});
      end
      checks++;
      if (cart_size !== '0 || cart_class !== CLASS_NONE) begin
         errors++;
         $display("FAIL reset_mid_size: got %0d/%0d, required 0/0", cart_size, cart_class);
      end
      m_size  = 0;
      m_class = CLASS_NONE;
      exp_q.delete();
      tick();
      tick();
      // SEL_CART still high at release: the session starts on the first edge.
      resb = 1'b1;
      tick();
      init_session(T_CART);
      for (int i = 0; i < 300; i++) send(i, 8'($urandom));
      end_session(1'b0, 0, 8'h00);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      exp_done = 1'b0;
      m_size   = 0;
      m_class  = CLASS_NONE;
      init_session(T_BOOT);
      clear_counts();
      test_reset();
      test_boot();
      test_cart_24k();
      test_cart_8k_random_order();
      test_overflow();
      test_conflict();
      test_last_byte();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
